// File: rtl/pipe_spawner.sv
// pipe_spawner
//   Consumer side of the 4-bit pseudo-random source. On scroll ticks it moves
//   every live pipe one column to the left and, at a fixed tick spacing, spawns
//   a new pipe at the right edge. The new pipe's gap row comes from the random
//   input. It pulses score when a pipe lands on the bird column.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high; clears everything
//   enable       game running (level)
//   tick         scroll strobe, one clk wide
//   rnd          free-running random value; only rnd[2:0] is used
//   pipe_valid   per-slot occupied flag
//   pipe_col     per-slot column, slot i at [i*COL_W +: COL_W]
//   pipe_gap     per-slot gap row, slot i at [i*4 +: 4]
//   spawn_pulse  one clk: a pipe was spawned
//   spawn_drop   one clk: a spawn was due but no slot was free
//   score_pulse  one clk: a pipe moved onto BIRD_COL
//   busy         FSM is not idle
module pipe_spawner #(
    parameter int COLS     = 16,
    parameter int COL_W    = 4,
    parameter int NPIPE    = 2,
    parameter int SPACING  = 8,
    parameter int BIRD_COL = 4,
    parameter int GAP_MIN  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   tick,
    input  logic [3:0]             rnd,
    output logic [NPIPE-1:0]       pipe_valid,
    output logic [NPIPE*COL_W-1:0] pipe_col,
    output logic [NPIPE*4-1:0]     pipe_gap,
    output logic                   spawn_pulse,
    output logic                   spawn_drop,
    output logic                   score_pulse,
    output logic                   busy
);

    localparam int CNT_W = $clog2(SPACING);
    localparam logic [COL_W-1:0] COL_START = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] COL_BIRD  = COL_W'(BIRD_COL);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SPACING - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nx;

    // Registered slot state and spawn countdown
    logic [NPIPE-1:0] valid_p1;
    logic [COL_W-1:0] col_p1 [NPIPE];
    logic [3:0]       gap_p1 [NPIPE];
    logic [CNT_W-1:0] cnt_p1;

    // Result of the move step, before any spawn
    logic [NPIPE-1:0] valid_p0;
    logic [COL_W-1:0] col_p0 [NPIPE];
    logic             score_p0;
    logic [NPIPE-1:0] spawn_sel_p0;
    logic             taken_p0;

    logic proc_tick;
    logic spawn_en;
    logic spawn_due;

    // rnd[3] carries no meaning for gap selection
    logic unused_rnd;
    assign unused_rnd = rnd[3];

    function automatic logic [3:0] gap_of(input logic [2:0] r);
        return 4'(GAP_MIN) + {1'b0, r};
    endfunction

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM: next state. enable takes priority over draining to idle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable) state_nx = RUN;
            RUN:     if (!enable) state_nx = DRAIN;
            DRAIN: begin
                if (enable)         state_nx = RUN;
                else if (~|valid_p1) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // A tick is processed whenever the game is not idle. Spawning additionally
    // needs enable in the same cycle, so the falling-enable tick only moves.
    assign proc_tick = tick && (state != IDLE);
    assign spawn_en  = proc_tick && enable;
    assign spawn_due = (cnt_p1 == '0);

    // Move stage: exits, column decrement, score detect, lowest free slot
    always_comb begin
        score_p0     = 1'b0;
        taken_p0     = 1'b0;
        spawn_sel_p0 = '0;
        for (int i = 0; i < NPIPE; i++) begin
            valid_p0[i] = valid_p1[i];
            col_p0[i]   = col_p1[i];
            if (valid_p1[i]) begin
                if (col_p1[i] == '0) begin
                    valid_p0[i] = 1'b0;
                end else begin
                    col_p0[i] = col_p1[i] - COL_W'(1);
                    if (col_p0[i] == COL_BIRD) score_p0 = 1'b1;
                end
            end
        end
        for (int i = 0; i < NPIPE; i++) begin
            if (!valid_p0[i] && !taken_p0) begin
                spawn_sel_p0[i] = 1'b1;
                taken_p0        = 1'b1;
            end
        end
    end

    // Register stage: slot update, countdown and pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_p1    <= '0;
            cnt_p1      <= '0;
            spawn_pulse <= 1'b0;
            spawn_drop  <= 1'b0;
            score_pulse <= 1'b0;
            for (int i = 0; i < NPIPE; i++) begin
                col_p1[i] <= '0;
                gap_p1[i] <= '0;
            end
        end else begin
            spawn_pulse <= 1'b0;
            spawn_drop  <= 1'b0;
            score_pulse <= 1'b0;
            // A fresh run always spawns on its first tick
            if (state == IDLE && enable) cnt_p1 <= '0;
            if (proc_tick) begin
                valid_p1    <= valid_p0;
                score_pulse <= score_p0;
                for (int i = 0; i < NPIPE; i++) col_p1[i] <= col_p0[i];
                if (spawn_en) begin
                    if (spawn_due) begin
                        cnt_p1 <= CNT_LOAD;
                        if (taken_p0) begin
                            spawn_pulse <= 1'b1;
                            for (int i = 0; i < NPIPE; i++) begin
                                if (spawn_sel_p0[i]) begin
                                    valid_p1[i] <= 1'b1;
                                    col_p1[i]   <= COL_START;
                                    gap_p1[i]   <= gap_of(rnd[2:0]);
                                end
                            end
                        end else begin
                            spawn_drop <= 1'b1;
                        end
                    end else begin
                        cnt_p1 <= cnt_p1 - CNT_W'(1);
                    end
                end
            end
        end
    end

    assign pipe_valid = valid_p1;

    for (genvar g = 0; g < NPIPE; g++) begin : g_pack
        assign pipe_col[g*COL_W +: COL_W] = col_p1[g];
        assign pipe_gap[g*4 +: 4]         = gap_p1[g];
    end

endmodule

// File: tb/tb_pipe_spawner.sv
module tb_pipe_spawner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, enable, tick;
    logic [3:0] rnd;

    logic [1:0] a_valid, b_valid;
    logic [7:0] a_col, a_gap, b_col, b_gap;
    logic       a_sp, a_dr, a_sc, a_busy;
    logic       b_sp, b_dr, b_sc, b_busy;

    pipe_spawner dut (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick), .rnd(rnd),
        .pipe_valid(a_valid), .pipe_col(a_col), .pipe_gap(a_gap),
        .spawn_pulse(a_sp), .spawn_drop(a_dr), .score_pulse(a_sc), .busy(a_busy)
    );

    pipe_spawner #(.SPACING(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick), .rnd(rnd),
        .pipe_valid(b_valid), .pipe_col(b_col), .pipe_gap(b_gap),
        .spawn_pulse(b_sp), .spawn_drop(b_dr), .score_pulse(b_sc), .busy(b_busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: per instance, pipes tracked by age since spawn;
    // column = 15 - age. Spawn cadence counted as run-ticks since last attempt.
    int  spc     [2] = '{8, 4};
    int  m_mode  [2];          // 0 idle, 1 run, 2 drain
    bit  m_v     [2][2];
    int  m_age   [2][2];
    int  m_gap   [2][2];
    bit  m_first [2];
    int  m_since [2];
    bit  m_sp [2], m_dr [2], m_sc [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_step(input int u, input bit r, input bit e, input bit t,
                              input logic [3:0] rn);
        bit any_v;
        int mode0;
        bit due;
        bit done;
        any_v = m_v[u][0] | m_v[u][1];
        mode0 = m_mode[u];
        m_sp[u] = 0; m_dr[u] = 0; m_sc[u] = 0;
        if (r) begin
            m_mode[u] = 0; m_first[u] = 0; m_since[u] = 0;
            for (int s = 0; s < 2; s++) begin
                m_v[u][s] = 0; m_age[u][s] = 15; m_gap[u][s] = 0;
            end
            return;
        end
        if (t && mode0 != 0) begin
            for (int s = 0; s < 2; s++) begin
                if (m_v[u][s]) begin
                    if (15 - m_age[u][s] == 0) m_v[u][s] = 0;
                    else begin
                        m_age[u][s]++;
                        if (15 - m_age[u][s] == 4) m_sc[u] = 1;
                    end
                end
            end
            if (e) begin
                if (m_first[u]) due = 1;
                else begin
                    m_since[u]++;
                    due = (m_since[u] == spc[u]);
                end
                if (due) begin
                    m_first[u] = 0;
                    m_since[u] = 0;
                    done = 0;
                    for (int s = 0; s < 2; s++) begin
                        if (!done && !m_v[u][s]) begin
                            m_v[u][s] = 1; m_age[u][s] = 0;
                            m_gap[u][s] = 1 + int'(rn[2:0]);
                            done = 1;
                        end
                    end
                    if (done) m_sp[u] = 1; else m_dr[u] = 1;
                end
            end
        end
        case (mode0)
            0: if (e) begin m_mode[u] = 1; m_first[u] = 1; end
            1: if (!e) m_mode[u] = 2;
            2: if (e) m_mode[u] = 1; else if (!any_v) m_mode[u] = 0;
            default: m_mode[u] = 0;
        endcase
    endtask

    task automatic compare_all(input int u);
        logic [1:0] v;
        logic [7:0] c, g;
        logic sp, dr, sc, bz;
        if (u == 0) begin v = a_valid; c = a_col; g = a_gap; sp = a_sp; dr = a_dr; sc = a_sc; bz = a_busy; end
        else        begin v = b_valid; c = b_col; g = b_gap; sp = b_sp; dr = b_dr; sc = b_sc; bz = b_busy; end
        chk($sformatf("u%0d valid", u), 32'(v), 32'({m_v[u][1], m_v[u][0]}));
        chk($sformatf("u%0d spawn_pulse", u), 32'(sp), 32'(m_sp[u]));
        chk($sformatf("u%0d spawn_drop", u), 32'(dr), 32'(m_dr[u]));
        chk($sformatf("u%0d score_pulse", u), 32'(sc), 32'(m_sc[u]));
        chk($sformatf("u%0d busy", u), 32'(bz), 32'(m_mode[u] != 0));
        for (int s = 0; s < 2; s++) begin
            if (m_v[u][s]) begin
                chk($sformatf("u%0d col%0d", u, s), 32'(c[s*4 +: 4]), 32'(15 - m_age[u][s]));
                chk($sformatf("u%0d gap%0d", u, s), 32'(g[s*4 +: 4]), 32'(m_gap[u][s]));
            end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit t, input logic [3:0] rn);
        reset = r; enable = e; tick = t; rnd = rn;
        @(posedge clk);
        model_step(0, r, e, t, rn);
        model_step(1, r, e, t, rn);
        #1;
        compare_all(0);
        compare_all(1);
    endtask

    typedef struct {
        bit         r, e, t;
        logic [3:0] rn;
        logic [1:0] v;
        bit         sp;
        bit         bz;
        logic [3:0] col0, gap0;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;
        bit toggle_en;
        reset = 1; enable = 0; tick = 0; rnd = 0;

        // Reset with enable/tick high, release, then first spawn with rnd=B
        tbl[0] = '{1, 1, 1, 4'h0, 2'b00, 0, 0, 4'd0,  4'd0};
        tbl[1] = '{1, 1, 1, 4'h0, 2'b00, 0, 0, 4'd0,  4'd0};
        tbl[2] = '{0, 1, 0, 4'h0, 2'b00, 0, 1, 4'd0,  4'd0};
        tbl[3] = '{0, 1, 1, 4'hB, 2'b01, 1, 1, 4'd15, 4'd4};
        tbl[4] = '{0, 1, 0, 4'h0, 2'b01, 0, 1, 4'd15, 4'd4};
        tbl[5] = '{0, 1, 0, 4'h7, 2'b01, 0, 1, 4'd15, 4'd4};
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].e, tbl[i].t, tbl[i].rn);
            chk($sformatf("tbl%0d valid", i), 32'(a_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d spawn", i), 32'(a_sp), 32'(tbl[i].sp));
            chk($sformatf("tbl%0d busy", i), 32'(a_busy), 32'(tbl[i].bz));
            chk($sformatf("tbl%0d score", i), 32'(a_sc), 32'd0);
            if (tbl[i].v[0]) begin
                chk($sformatf("tbl%0d col0", i), 32'(a_col[3:0]), 32'(tbl[i].col0));
                chk($sformatf("tbl%0d gap0", i), 32'(a_gap[3:0]), 32'(tbl[i].gap0));
            end
        end

        // Scroll with rnd=0: score at tick 11, second spawn at 8, reuse at 16
        for (int k = 1; k <= 16; k++) begin
            cyc(0, 1, 1, 4'h0);
            chk($sformatf("t3 score k%0d", k), 32'(a_sc), 32'(k == 11));
            if (k == 8) begin
                chk("t3 slot1 spawn", 32'(a_sp), 32'd1);
                chk("t3 slot1 valid", 32'(a_valid[1]), 32'd1);
                chk("t3 slot1 gap", 32'(a_gap[7:4]), 32'd1);
                chk("t4 sp4 drop", 32'(b_dr), 32'd1);
            end
            if (k == 15) chk("t3 col0 zero", 32'(a_col[3:0]), 32'd0);
            if (k == 16) begin
                chk("t4 reuse spawn", 32'(a_sp), 32'd1);
                chk("t4 reuse nodrop", 32'(a_dr), 32'd0);
                chk("t4 reuse col", 32'(a_col[3:0]), 32'd15);
            end
            cyc(0, 1, 0, 4'h0);
        end

        // Drop enable with two pipes live: drain to idle without spawning
        steps = 0;
        while ((a_busy || b_busy) && steps < 200) begin
            cyc(0, 0, (steps % 2) == 0, 4'($urandom));
            chk("t5 no spawn", 32'(a_sp | b_sp), 32'd0);
            steps++;
        end
        chk("t5 drained", 32'(a_busy | b_busy), 32'd0);

        // Reset mid-run with both slots valid and tick high
        cyc(0, 1, 0, 4'h0);
        for (int k = 0; k <= 8; k++) cyc(0, 1, 1, 4'($urandom));
        chk("t6 both valid", 32'(a_valid), 32'd3);
        cyc(1, 1, 1, 4'h5);
        chk("t6 cleared", 32'(a_valid | b_valid), 32'd0);
        chk("t6 no pulses", 32'({a_sp, a_sc, b_sp, b_sc}), 32'd0);
        chk("t6 idle", 32'(a_busy | b_busy), 32'd0);

        // Randomized run against the model
        toggle_en = 1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 39) == 0) toggle_en = !toggle_en;
            cyc($urandom_range(0, 499) == 0, toggle_en, $urandom_range(0, 1) == 1,
                4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
